fc_neuron_seq: RTL and testbench
================================

FC_NEURON_SEQ -- requirements
Module: fc_neuron_seq

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, signed width of pixel, weight and score elements.
REQ-002 The block SHALL have parameter NUM_KERNELS, default 2, number of pooled kernel maps.
REQ-003 The block SHALL have parameter PIX_PER_KERNEL, default 4, pooled pixels per kernel; NUM_IN = NUM_KERNELS*PIX_PER_KERNEL.
REQ-004 The block SHALL have parameter NUM_CLASSES, default 4, number of output neurons (classes).
REQ-005 The block SHALL have ports: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have ports: w_wr_en  in  1  weight write strobe; w_wr_class  in  clog2(NUM_CLASSES)  target class; w_wr_data  in  NUM_IN*DATA_W  weight vector.
REQ-007 The block SHALL have ports: in_valid  in  1; in_ready  out  1; pix_in  in  NUM_IN*DATA_W  pooled pixel vector.
REQ-008 The block SHALL have ports: out_valid  out  1; out_ready  in  1; class_idx  out  clog2(NUM_CLASSES)  winning class; score_vec  out  NUM_CLASSES*DATA_W  per-class scores.
REQ-009 Element i of pix_in, w_wr_data and class c of score_vec SHALL occupy bits [i*DATA_W +: DATA_W] and [c*DATA_W +: DATA_W]; all elements two's-complement.

Function
REQ-010 Weights SHALL be held in an internal NUM_CLASSES x NUM_IN register bank written on clk when w_wr_en=1 and state=IDLE; writes in any other state SHALL be dropped.
REQ-011 FSM states SHALL be IDLE, MAC, FINAL, DONE.
REQ-012 IDLE: in_ready=1; on in_valid&&in_ready, pix_in SHALL be captured, class/element counters cleared, accumulator cleared, go to MAC.
REQ-013 MAC: one signed DATA_W x DATA_W multiply per cycle, added into an accumulator of width 2*DATA_W+clog2(NUM_IN); elements 0..NUM_IN-1 for class 0, then class 1, etc.
REQ-014 At the last element of each class the sum SHALL be saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], written to that class's score slot, accumulator cleared.
REQ-015 After the last element of the last class, go to FINAL; FINAL computes argmax over saturated scores (ties: lowest index) and goes to DONE.
REQ-016 DONE: out_valid=1, class_idx and score_vec stable; on out_ready=1 go to IDLE.
REQ-017 Latency SHALL be NUM_CLASSES*NUM_IN+1 cycles from the accepting edge to the edge asserting out_valid (33 with defaults).
REQ-018 in_ready SHALL be 0 in MAC, FINAL, DONE; out_valid SHALL be 0 outside DONE.
REQ-019 A weight write and input acceptance in the same IDLE cycle SHALL both occur; the computation SHALL use the newly written weights.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state IDLE, counters and accumulator to 0, out_valid=0, class_idx=0, score_vec=0; weight bank cleared to 0.
REQ-021 Reset during MAC/FINAL/DONE SHALL abort the computation with no out_valid pulse; in_ready=1 on the first cycle after rst_n rises.

Configuration
REQ-022 With macro FC_NEURON_RELU_EN defined, each saturated score SHALL be clamped to >=0 before storage and argmax; without it, signed scores SHALL be stored and compared unmodified.

Verification
REQ-023 Load weights class0=X {01ffff01,ff0101ff}, class1 {ff0101ff,01ffff01}, class2 {ffffffff,ff0101ff}, class3 {01ffff01,ffffffff} (bytes MSB-first per kernel); pix X -> scores {8,-8,4,4}, class_idx=0, out_valid 33 cycles after accept.
REQ-024 Same weights, pix {ff0101ff,01ffff01} -> scores {-8,8,-4,-4}, class_idx=1; with FC_NEURON_RELU_EN -> {0,8,0,0}, class_idx=1.
REQ-025 All weights and pixels 0x7f -> every score saturates to 127, class_idx=0 (tie); all 0x80 pixels with 0x7f weights -> -128 (0 with RELU).
REQ-026 Hold out_ready=0 for 10 cycles in DONE -> out_valid, class_idx, score_vec unchanged, in_ready=0, pixel offers ignored; release -> IDLE next cycle.
REQ-027 Assert rst_n=0 mid-MAC (cycle 10) -> outputs zero, no out_valid; weight write attempted during MAC is ignored (subsequent run shows old weights).

Source files
------------

// File: rtl/fc_neuron_seq.sv
// Sequential fully-connected classifier neuron: one signed MAC per cycle, per-class saturation, argmax.
// Optional build macro FC_NEURON_RELU_EN clamps every saturated score to >= 0 before storage and argmax.
module fc_neuron_seq #(
  parameter  int DATA_W         = 8,
  parameter  int NUM_KERNELS    = 2,
  parameter  int PIX_PER_KERNEL = 4,
  parameter  int NUM_CLASSES    = 4,
  localparam int NUM_IN         = NUM_KERNELS * PIX_PER_KERNEL,
  localparam int CLS_W          = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          w_wr_en,
  input  logic [CLS_W-1:0]              w_wr_class,
  input  logic [NUM_IN*DATA_W-1:0]      w_wr_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_IN*DATA_W-1:0]      pix_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CLS_W-1:0]              class_idx,
  output logic [NUM_CLASSES*DATA_W-1:0] score_vec
);

  localparam int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + IDX_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic signed [DATA_W-1:0]   r_w     [NUM_CLASSES][NUM_IN];
  logic signed [DATA_W-1:0]   r_pix   [NUM_IN];
  logic signed [DATA_W-1:0]   r_score [NUM_CLASSES];
  logic [CLS_W-1:0]           r_cls;
  logic [IDX_W-1:0]           r_elem;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_in_ready;
  logic                       r_out_valid;
  logic [CLS_W-1:0]           r_class_idx;
  logic [NUM_CLASSES*DATA_W-1:0] r_score_vec;

  logic                       w_accept;
  logic                       w_wr_ok;
  logic                       w_last_elem;
  logic                       w_last_cls;
  logic signed [DATA_W-1:0]   w_pix_cur;
  logic signed [DATA_W-1:0]   w_wt_cur;
  logic signed [PROD_W-1:0]   w_pix_ext;
  logic signed [PROD_W-1:0]   w_wt_ext;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [DATA_W-1:0]   w_sat;
  logic signed [DATA_W-1:0]   w_best_val;
  logic [CLS_W-1:0]           w_best_idx;

  // Clamp a wide accumulator to the signed DATA_W score range (and to >= 0 when ReLU is built in).
  function automatic logic signed [DATA_W-1:0] sat_score(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0]  hi;
    logic signed [ACC_W-1:0]  lo;
    logic signed [DATA_W-1:0] s;
    hi = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    lo = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    if (v > hi) begin
      s = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (v < lo) begin
      s = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      s = v[DATA_W-1:0];
    end
`ifdef FC_NEURON_RELU_EN
    if (s[DATA_W-1]) begin
      s = {DATA_W{1'b0}};
    end else begin
      s = s;
    end
`endif
    return s;
  endfunction

  assign w_accept    = in_valid && r_in_ready;
  assign w_wr_ok     = w_wr_en && (r_state == S_IDLE);
  assign w_last_elem = (r_elem == IDX_W'(NUM_IN - 1));
  assign w_last_cls  = (r_cls == CLS_W'(NUM_CLASSES - 1));
  assign w_pix_cur   = r_pix[r_elem];
  assign w_wt_cur    = r_w[r_cls][r_elem];
  assign w_pix_ext   = {{DATA_W{w_pix_cur[DATA_W-1]}}, w_pix_cur};
  assign w_wt_ext    = {{DATA_W{w_wt_cur[DATA_W-1]}}, w_wt_cur};
  assign w_prod      = w_pix_ext * w_wt_ext;
  assign w_sum       = r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_sat       = sat_score(w_sum);

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign class_idx = r_class_idx;
  assign score_vec = r_score_vec;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_MAC;
        else          w_state_nxt = S_IDLE;
      end
      S_MAC: begin
        if (w_last_elem && w_last_cls) w_state_nxt = S_FINAL;
        else                           w_state_nxt = S_MAC;
      end
      S_FINAL: w_state_nxt = S_DONE;
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strictly-greater scan keeps the lowest index on ties.
  always_comb begin
    w_best_val = r_score[0];
    w_best_idx = {CLS_W{1'b0}};
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (r_score[c] > w_best_val) begin
        w_best_val = r_score[c];
        w_best_idx = CLS_W'(c);
      end else begin
        w_best_val = w_best_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        for (int i = 0; i < NUM_IN; i++) r_w[c][i] <= {DATA_W{1'b0}};
        r_score[c] <= {DATA_W{1'b0}};
      end
      for (int i = 0; i < NUM_IN; i++) r_pix[i] <= {DATA_W{1'b0}};
      r_cls       <= {CLS_W{1'b0}};
      r_elem      <= {IDX_W{1'b0}};
      r_acc       <= {ACC_W{1'b0}};
      r_class_idx <= {CLS_W{1'b0}};
      r_score_vec <= {(NUM_CLASSES*DATA_W){1'b0}};
    end else begin
      if (w_wr_ok) begin
        for (int i = 0; i < NUM_IN; i++) r_w[w_wr_class][i] <= w_wr_data[i*DATA_W +: DATA_W];
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            for (int i = 0; i < NUM_IN; i++) r_pix[i] <= pix_in[i*DATA_W +: DATA_W];
            r_cls  <= {CLS_W{1'b0}};
            r_elem <= {IDX_W{1'b0}};
            r_acc  <= {ACC_W{1'b0}};
          end
        end
        S_MAC: begin
          if (w_last_elem) begin
            r_score[r_cls] <= w_sat;
            r_acc          <= {ACC_W{1'b0}};
            r_elem         <= {IDX_W{1'b0}};
            r_cls          <= w_last_cls ? {CLS_W{1'b0}} : (r_cls + CLS_W'(1'b1));
          end else begin
            r_acc  <= w_sum;
            r_elem <= r_elem + IDX_W'(1'b1);
          end
        end
        S_FINAL: begin
          r_class_idx <= w_best_idx;
          for (int c = 0; c < NUM_CLASSES; c++) r_score_vec[c*DATA_W +: DATA_W] <= r_score[c];
        end
        S_DONE: begin
          r_cls <= r_cls;
        end
        default: begin
          r_cls <= {CLS_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_neuron_seq.sv
// Scoreboard bench for fc_neuron_seq: a behavioural weight/score model predicts each result at acceptance.
module tb_fc_neuron_seq;
  localparam int DW = 8;
  localparam int NC = 4;
  localparam int NI = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              w_wr_en;
  logic [1:0]        w_wr_class;
  logic [NI*DW-1:0]  w_wr_data;
  logic              in_valid;
  logic              in_ready;
  logic [NI*DW-1:0]  pix_in;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        class_idx;
  logic [NC*DW-1:0]  score_vec;

  typedef struct packed {
    logic [NC*DW-1:0] sv;
    logic [1:0]       ci;
  } exp_t;

  exp_t   sb[$];
  int     wm [NC][NI];
  int     n_checks = 0;
  int     n_pass   = 0;
  longint t_acc;

  localparam logic [63:0] W_X  = 64'hff0101ff_01ffff01;
  localparam logic [63:0] W_Y  = 64'h01ffff01_ff0101ff;
  localparam logic [63:0] W_C2 = 64'hff0101ff_ffffffff;
  localparam logic [63:0] W_C3 = 64'hffffffff_01ffff01;

  always #5 clk = ~clk;

  fc_neuron_seq #(.DATA_W(DW), .NUM_KERNELS(2), .PIX_PER_KERNEL(4), .NUM_CLASSES(NC)) dut (
    .clk(clk), .rst_n(rst_n), .w_wr_en(w_wr_en), .w_wr_class(w_wr_class), .w_wr_data(w_wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .pix_in(pix_in),
    .out_valid(out_valid), .out_ready(out_ready), .class_idx(class_idx), .score_vec(score_vec)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [NI*DW-1:0] pix);
    exp_t e;
    int   s [NC];
    int   acc;
    int   best;
    logic signed [DW-1:0] b;
    int   p;
    for (int c = 0; c < NC; c++) begin
      acc = 0;
      for (int i = 0; i < NI; i++) begin
        b = pix[i*DW +: DW];
        p = b;
        acc += p * wm[c][i];
      end
      if (acc > 127) acc = 127;
      if (acc < -128) acc = -128;
`ifdef FC_NEURON_RELU_EN
      if (acc < 0) acc = 0;
`endif
      s[c] = acc;
    end
    best = 0;
    for (int c = 1; c < NC; c++) if (s[c] > s[best]) best = c;
    for (int c = 0; c < NC; c++) e.sv[c*DW +: DW] = s[c][DW-1:0];
    e.ci = best[1:0];
    return e;
  endfunction

  task automatic model_write(input int cls, input logic [63:0] data);
    logic signed [DW-1:0] b;
    for (int i = 0; i < NI; i++) begin
      b = data[i*DW +: DW];
      wm[cls][i] = b;
    end
  endtask

  task automatic write_w(input int cls, input logic [63:0] data, input bit taken);
    @(negedge clk);
    w_wr_en    = 1'b1;
    w_wr_class = cls[1:0];
    w_wr_data  = data;
    if (taken) model_write(cls, data);
    @(posedge clk);
    #1;
    w_wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [63:0] pix, input bit do_wr, input int cls, input logic [63:0] data);
    @(negedge clk);
    check_eq("ready_before_offer", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    pix_in   = pix;
    if (do_wr) begin
      w_wr_en    = 1'b1;
      w_wr_class = cls[1:0];
      w_wr_data  = data;
      model_write(cls, data);
    end
    sb.push_back(model(pix));
    @(posedge clk);
    t_acc = $time;
    #1;
    in_valid = 1'b0;
    w_wr_en  = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int hold);
    int     guard;
    longint lat;
    exp_t   e;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    lat = ($time - t_acc - 1) / 10;
    check_eq({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
    check_eq({tag, "_latency"}, 64'(lat), 64'd33);
    check_eq({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check_eq({tag, "_score_vec"}, {32'd0, score_vec}, {32'd0, e.sv});
    check_eq({tag, "_class_idx"}, {62'd0, class_idx}, {62'd0, e.ci});
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      pix_in   = {$urandom, $urandom};
      @(posedge clk);
      #1;
      check_eq({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
      check_eq({tag, "_hold_ready"}, {63'd0, in_ready}, 64'd0);
      check_eq({tag, "_hold_sv"}, {32'd0, score_vec}, {32'd0, e.sv});
      check_eq({tag, "_hold_ci"}, {62'd0, class_idx}, {62'd0, e.ci});
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_release_valid"}, {63'd0, out_valid}, 64'd0);
    check_eq({tag, "_release_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int highs;
    rst_n = 1'b0; w_wr_en = 1'b0; w_wr_class = 2'd0; w_wr_data = 64'd0;
    in_valid = 1'b0; pix_in = 64'd0; out_ready = 1'b0;
    for (int c = 0; c < NC; c++) for (int i = 0; i < NI; i++) wm[c][i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_class_idx", {62'd0, class_idx}, 64'd0);
    check_eq("rst_score_vec", {32'd0, score_vec}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);

    write_w(0, W_X, 1'b1);
    write_w(1, W_Y, 1'b1);
    write_w(2, W_C2, 1'b1);
    write_w(3, W_C3, 1'b1);
    start_run(W_X, 1'b0, 0, 64'd0);
    finish_run("pat_x", 0);
    start_run(W_Y, 1'b0, 0, 64'd0);
    finish_run("pat_y", 0);

    start_run(W_X, 1'b1, 3, W_X);
    finish_run("same_cycle_write", 0);

    start_run(W_Y, 1'b0, 0, 64'd0);
    finish_run("backpressure", 10);

    start_run(W_X, 1'b0, 0, 64'd0);
    repeat (4) @(posedge clk);
    write_w(0, {$urandom, $urandom}, 1'b0);
    finish_run("write_in_mac", 0);
    start_run(W_X, 1'b0, 0, 64'd0);
    finish_run("old_weights", 0);

    for (int c = 0; c < NC; c++) write_w(c, {8{8'h7f}}, 1'b1);
    start_run({8{8'h7f}}, 1'b0, 0, 64'd0);
    finish_run("sat_pos", 0);
    start_run({8{8'h80}}, 1'b0, 0, 64'd0);
    finish_run("sat_neg", 0);

    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < NC; c++) write_w(c, {$urandom, $urandom}, 1'b1);
      start_run({$urandom, $urandom}, 1'b0, 0, 64'd0);
      finish_run("random", 0);
    end

    start_run(W_Y, 1'b0, 0, 64'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("midreset_score_vec", {32'd0, score_vec}, 64'd0);
    check_eq("midreset_class_idx", {62'd0, class_idx}, 64'd0);
    sb.delete();
    for (int c = 0; c < NC; c++) for (int i = 0; i < NI; i++) wm[c][i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    highs = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) highs++;
    end
    check_eq("midreset_no_valid", 64'(highs), 64'd0);
    start_run(W_X, 1'b0, 0, 64'd0);
    finish_run("cleared_weights", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
